// File: rtl/booth_mul8.sv
// Sequential 8x8 signed multiplier using radix-2 Booth recoding.
// One ADD/SHIFT pair per multiplier bit, then a one-cycle DONE pulse.
module booth_mul8 (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [8:0]  acc;
  logic [7:0]  q;
  logic        q_m1;
  logic [8:0]  m_ext;
  logic [2:0]  cnt;

  logic [8:0]  addend;
  logic        carry_in;
  logic [8:0]  sum;
  logic [8:0]  acc_add;
  logic [8:0]  acc_shift;
  logic [7:0]  q_shift;

  // One shared 9-bit adder: subtraction is ~M with carry-in set, carry-out dropped.
  always_comb begin
    addend    = q[0] ? ~m_ext : m_ext;
    carry_in  = q[0];
    sum       = acc + addend + {8'b0, carry_in};
    acc_add   = (q[0] ^ q_m1) ? sum : acc;
    acc_shift = {acc[8], acc[8:1]};
    q_shift   = {acc[0], q[7:1]};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = (cnt == 3'd7) ? DONE : ADD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      m_ext   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            q     <= mplier;
            q_m1  <= 1'b0;
            m_ext <= {mcand[7], mcand};
            cnt   <= '0;
          end
        end
        ADD: acc <= acc_add;
        SHIFT: begin
          acc  <= acc_shift;
          q    <= q_shift;
          q_m1 <= q[0];
          // The product is taken from the post-shift value on the last iteration.
          if (cnt == 3'd7) product <= {acc_shift[7:0], q_shift};
          else             cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ADD) || (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_mul8.sv
// Randomized bench for booth_mul8, checked against a signed arithmetic model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_booth_mul8;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  booth_mul8 dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = int'($signed(a)) * int'($signed(b));
    return r[15:0];
  endfunction

  // Runs one operation; latency counts falling edges after the start edge until done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int busy_cycles,
                       output int latency, output int done_width,
                       output bit hold_ok, output bit timeout);
    logic [15:0] prev;
    @(negedge clk);
    mcand = a;
    mplier = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mcand = 8'($urandom);
    mplier = 8'($urandom);
    prev = product;
    hold_ok = 1'b1;
    busy_cycles = 0;
    latency = 0;
    timeout = 1'b0;
    while (!done && latency < 40) begin
      if (busy) busy_cycles++;
      if (product !== prev) hold_ok = 1'b0;
      latency++;
      @(negedge clk);
    end
    if (!done) timeout = 1'b1;
    p = product;
    done_width = 0;
    while (done && done_width < 5) begin
      done_width++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    start = 1'b0;
    mcand = 8'h00;
    mplier = 8'h00;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0000",
               busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_directed;
    logic [7:0]  a_list [8] = '{8'h07, 8'h80, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01};
    logic [7:0]  b_list [8] = '{8'h03, 8'h80, 8'h7F, 8'hFF, 8'h5A, 8'h7F, 8'h01, 8'h80};
    logic [15:0] p;
    logic [15:0] exp;
    int bc, lat, dw;
    bit hold, to;
    for (int i = 0; i < 8; i++) begin
      do_op(a_list[i], b_list[i], p, bc, lat, dw, hold, to);
      exp = ref_mul(a_list[i], b_list[i]);
      checks++;
      if (to || p !== exp) begin
        errors++;
        $display("[TB] FAIL directed_product %h*%h: got %h, required %h (timeout=%0d)",
                 a_list[i], b_list[i], p, exp, to);
      end
      checks++;
      if (lat != 16 || bc != 16 || dw != 1) begin
        errors++;
        $display("[TB] FAIL directed_timing %h*%h: latency=%0d busy=%0d done_width=%0d, required 16 16 1",
                 a_list[i], b_list[i], lat, bc, dw);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic [15:0] exp;
    int bc, lat, dw;
    bit hold, to;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      do_op(a, b, p, bc, lat, dw, hold, to);
      exp = ref_mul(a, b);
      checks++;
      if (to || p !== exp || dw != 1 || lat != 16 || !hold) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("[TB] FAIL random_op %h*%h: got %h lat=%0d dw=%0d hold=%0d, required %h lat=16 dw=1 hold=1",
                   a, b, p, lat, dw, hold, exp);
      end
    end
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    int late_busy = 0;
    logic [15:0] p = '0;
    @(negedge clk);
    mcand = 8'd7;
    mplier = 8'd3;
    start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 4) begin
        mcand = 8'd2;
        mplier = 8'd2;
        start = 1'b1;
      end
      if (n == 5) mcand = 8'd9;
      if (done) begin
        dones++;
        p = product;
      end
      if (n > 18 && busy) late_busy++;
    end
    checks++;
    if (dones != 1 || late_busy != 0) begin
      errors++;
      $display("[TB] FAIL ignore_start: done_cycles=%0d busy_after=%0d, required 1 0", dones, late_busy);
    end
    checks++;
    if (p !== 16'h0015) begin
      errors++;
      $display("[TB] FAIL ignore_start_product: got %h, required 0015", p);
    end
  endtask

  task automatic test_back_to_back;
    int d_idx [$];
    logic [15:0] d_prod [$];
    @(negedge clk);
    mcand = 8'hF3;
    mplier = 8'h25;
    start = 1'b1;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (n == 0) begin
        mcand = 8'h6B;
        mplier = 8'h9C;
      end
      if (n == 18) start = 1'b0;
      if (done) begin
        d_idx.push_back(n);
        d_prod.push_back(product);
      end
    end
    checks++;
    if (d_idx.size() != 2) begin
      errors++;
      $display("[TB] FAIL back_to_back_count: got %0d done cycles, required 2", d_idx.size());
    end else begin
      checks++;
      if (d_idx[0] != 16 || d_idx[1] != 34) begin
        errors++;
        $display("[TB] FAIL back_to_back_timing: done at %0d,%0d, required 16,34", d_idx[0], d_idx[1]);
      end
      checks++;
      if (d_prod[0] !== ref_mul(8'hF3, 8'h25) || d_prod[1] !== ref_mul(8'h6B, 8'h9C)) begin
        errors++;
        $display("[TB] FAIL back_to_back_product: got %h,%h, required %h,%h", d_prod[0], d_prod[1],
                 ref_mul(8'hF3, 8'h25), ref_mul(8'h6B, 8'h9C));
      end
    end
  endtask

  task automatic test_mid_reset;
    int dones = 0;
    logic [15:0] p;
    int bc, lat, dw;
    bit hold, to;
    @(negedge clk);
    mcand = 8'd100;
    mplier = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL mid_reset: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 2) rst_b = 1'b1;
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || product !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL mid_reset_abort: done_cycles=%0d product=%h, required 0 0000", dones, product);
    end
    do_op(8'd5, 8'hFA, p, bc, lat, dw, hold, to);
    checks++;
    if (to || p !== 16'hFFE2 || lat != 16) begin
      errors++;
      $display("[TB] FAIL after_reset_op: got %h lat=%0d, required FFE2 lat=16", p, lat);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mul8.md
BOOTH_MUL8 -- requirements
Module: booth_mul8

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with the ports listed below.
  clk       input   1   rising-edge clock
  rst_b     input   1   asynchronous active-low reset
  start     input   1   request; sampled only in IDLE
  mcand     input   8   signed multiplicand, two's complement
  mplier    input   8   signed multiplier, two's complement
  busy      output  1   high in ADD and SHIFT states
  done      output  1   one-cycle completion pulse, high in DONE state
  product   output  16  signed product, registered

Function
REQ-002 The block SHALL compute product = mcand * mplier using radix-2 Booth recoding, sequentially.
REQ-003 The datapath SHALL contain the following registers:
  - A: 9 bits, accumulator.
  - Q: 8 bits, multiplier.
  - Qm1: 1 bit.
  - M: 9 bits, mcand sign-extended.
  - cnt: 3 bits.
  - state.
REQ-004 The FSM SHALL have the states IDLE, ADD, SHIFT and DONE; the encoding is free.
REQ-005 IDLE -> ADD when start=1; in the same edge the block SHALL load:
  - A=0.
  - Q=mplier.
  - Qm1=0.
  - M={mcand[7],mcand}.
  - cnt=0.
REQ-006 IDLE with start=0 SHALL remain IDLE with no register changes.
REQ-007 In ADD, {Q[0],Qm1} SHALL select the accumulator update: 01 -> A=A+M; 10 -> A=A+~M+1 (subtract via carry-in=1); 00/11 -> A unchanged. Next state SHALL be SHIFT.
REQ-008 Add and subtract SHALL use a single 9-bit two's-complement adder with its carry-out discarded.
REQ-009 In SHIFT, {A,Q,Qm1} SHALL be arithmetic-shifted right by one bit, with A[8] replicated into A[8].
REQ-010 In SHIFT, if cnt==7, next state SHALL be DONE and product SHALL load {A[7:0],Q} post-shift; otherwise cnt SHALL increment and next state SHALL be ADD.
REQ-011 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-012 Latency: with start sampled at edge E0, done SHALL be high in the cycle following edge E16 and low again after E17.
REQ-013 Minimum spacing between start captures SHALL be 18 cycles.
REQ-014 start SHALL be ignored in ADD, SHIFT and DONE.
REQ-015 A start held high continuously SHALL begin a new operation at the first IDLE edge.
REQ-016 mcand and mplier SHALL be captured only at the start edge; later input changes SHALL not affect the result.
REQ-017 product SHALL hold its value from completion until the next completion; it SHALL not change during an operation.
REQ-018 busy and done SHALL be decoded from the state register only, with no combinational path from inputs.
REQ-019 The result SHALL be exact for all 65536 operand pairs, including -128*-128 = +16384 (0x4000); no overflow condition exists.

Reset
REQ-020 On rst_b=0 the block SHALL immediately, regardless of clk, set:
  - state=IDLE.
  - A=0, Q=0, Qm1=0, M=0, cnt=0.
  - product=0x0000.
  - busy=0, done=0.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no done pulse; product SHALL read 0x0000.
REQ-022 After rst_b deasserts, the first rising edge with start=1 SHALL begin a normal operation.

Verification
REQ-023 mcand=7, mplier=3, start pulse -> done after 16 cycles, product=0x0015; busy high for exactly 16 cycles.
REQ-024 mcand=-128 (0x80), mplier=-128 -> product=0x4000; mcand=0x80, mplier=0x7F -> product=0xC080 (-16256).
REQ-025 mcand=0xFF, mplier=0xFF -> product=0x0001; mcand=0x00, mplier=0x5A -> product=0x0000.
REQ-026 Start 7*3, then pulse start with 2*2 at cycle 5 and change mcand to 9 at cycle 6 -> single done, product=0x0015; no second operation begins.
REQ-027 Start 100*100, then assert rst_b=0 at cycle 8 -> busy=0, done=0 and product=0x0000 immediately; after release, 5*-6 -> product=0xFFE2.
REQ-028 Exhaustive sweep of all operand pairs against a signed reference model -> zero mismatches, with done pulse width exactly 1 cycle every time.
